// File: rtl/rcs_pkg.sv
// ----------------------------------------------------------------------------
// rcs_pkg
// Shared types and helpers for ripple_count_sampler.
//   rcs_state_t : sampler state (SEED until the first value is accepted,
//                 then TRACK)
//   ERR_CNT_W   : width of the optional step-error counter
//   rcs_delta   : source step distance between two accepted counts,
//                 taken modulo 2^in_w and oriented by count direction
// ----------------------------------------------------------------------------
package rcs_pkg;

    typedef enum logic [0:0] {
        SEED  = 1'b0,
        TRACK = 1'b1
    } rcs_state_t;

    localparam int ERR_CNT_W = 8;

    // Number of source steps taken to move from 'last' to 'cand'.
    // A down-counter moves last -> last-1, so its distance is last-cand.
    function automatic int unsigned rcs_delta(
        input int unsigned last,
        input int unsigned cand,
        input int unsigned in_w,
        input bit          down
    );
        int unsigned mask;
        mask = (32'd1 << in_w) - 32'd1;
        if (down) return (last - cand) & mask;
        else      return (cand - last) & mask;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer with asynchronous active-high reset.
//   clk : destination clock
//   rst : asynchronous reset, active high (both stages clear to 0)
//   d   : asynchronous input bit
//   q   : synchronized output (second stage)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// ripple_count_sampler
// Samples an asynchronous ripple counter into the clk domain, filters out
// ripple-settling glitches, and converts accepted count changes into a
// saturating event accumulator plus wrap / step-error / drop pulses.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cnt_in      : ripple counter bits (asynchronous, bits not coherent)
//   clr         : synchronous clear of acc, acc_sat, out_valid, baseline
//   out_ready   : consumer accepts out_count
//   out_valid   : out_count holds an unconsumed accepted value
//   out_count   : last accepted count
//   acc         : saturating total of source steps since reset/clr
//   acc_sat     : sticky, acc reached all-ones
//   wrap_pulse  : one cycle, source wrapped
//   step_err    : one cycle, accepted step distance was not 1
//   drop_pulse  : one cycle, an unconsumed out_count was overwritten
//   err_cnt     : (only with RCS_ERR_CNT_EN) saturating count of step_err
//   state_dbg   : current sampler state (0 = SEED, 1 = TRACK)
//
// Output handshake: out_count is offered while out_valid is high and is
// consumed on any cycle with out_valid && out_ready. A new accept always
// loads out_count and holds out_valid high; if the old value was not being
// consumed in that cycle, drop_pulse marks the loss.
//
// Optional build macro: RCS_ERR_CNT_EN adds the err_cnt output.
// ----------------------------------------------------------------------------
module ripple_count_sampler
    import rcs_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int STABLE_N = 2,
    parameter int ACC_W    = 16,
    parameter int DOWN     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      cnt_in,
    input  logic                 clr,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [IN_W-1:0]      out_count,
    output logic [ACC_W-1:0]     acc,
    output logic                 acc_sat,
    output logic                 wrap_pulse,
    output logic                 step_err,
    output logic                 drop_pulse,
`ifdef RCS_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                 state_dbg
);

    localparam int SW = (STABLE_N > 1) ? $clog2(STABLE_N) + 1 : 1;
    localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_N - 1);
    localparam logic [IN_W-1:0] CNT_MAX  = '1;

    logic [IN_W-1:0]  s2;
    logic [IN_W-1:0]  cand;
    logic [SW-1:0]    stab_cnt;
    logic [IN_W-1:0]  last_q;
    rcs_state_t       state_q;

    logic             accept;
    logic [IN_W-1:0]  delta;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             wrap;

    for (genvar i = 0; i < IN_W; i++) begin : g_sync
        sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d   (cnt_in[i]),
            .q   (s2[i])
        );
    end

    // Stability filter. stab_cnt saturates at STAB_MAX so a value that was
    // already stable when clr wiped the baseline is accepted right away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (s2 != cand) begin
            cand     <= s2;
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + SW'(1);
        end
    end

    always_comb begin
        accept   = (stab_cnt == STAB_MAX) && (cand != last_q);
        delta    = IN_W'(rcs_delta(32'(last_q), 32'(cand), 32'(IN_W), DOWN != 0));
        acc_sum  = {1'b0, acc} + (ACC_W+1)'(delta);
        acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        if (DOWN != 0) wrap = (last_q == '0) && (cand == CNT_MAX);
        else           wrap = (last_q == CNT_MAX) && (cand == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEED;
            last_q     <= '0;
            out_valid  <= 1'b0;
            out_count  <= '0;
            acc        <= '0;
            acc_sat    <= 1'b0;
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
            drop_pulse <= 1'b0;
            if (clr) begin
                state_q   <= SEED;
                last_q    <= '0;
                out_valid <= 1'b0;
                acc       <= '0;
                acc_sat   <= 1'b0;
            end else begin
                if (out_valid && out_ready) out_valid <= 1'b0;
                if (accept) begin
                    last_q    <= cand;
                    out_count <= cand;
                    out_valid <= 1'b1;
                    if (out_valid && !out_ready) drop_pulse <= 1'b1;
                    // The seeding accept only establishes the baseline.
                    if (state_q == TRACK) begin
                        acc        <= acc_next;
                        if (acc_next == '1) acc_sat <= 1'b1;
                        wrap_pulse <= wrap;
                        step_err   <= (delta != IN_W'(1));
                    end
                    state_q <= TRACK;
                end
            end
        end
    end

`ifdef RCS_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (accept && (state_q == TRACK) && (delta != IN_W'(1))
                     && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

    assign state_dbg = state_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// tb_ripple_count_sampler
// Directed self-checking bench for ripple_count_sampler (default parameters:
// IN_W=4, STABLE_N=2, ACC_W=16, DOWN=1). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ripple_count_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cnt_in;
    logic        clr;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_count;
    logic [15:0] acc;
    logic        acc_sat;
    logic        wrap_pulse;
    logic        step_err;
    logic        drop_pulse;
    logic        state_dbg;
`ifdef RCS_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // pulse / event counters, written only by the monitor
    int wrap_seen = 0;
    int err_seen  = 0;
    int drop_seen = 0;
    int zero_seen = 0;

    logic [3:0] v;

    always #5 clk = ~clk;

    ripple_count_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_count  (out_count),
        .acc        (acc),
        .acc_sat    (acc_sat),
        .wrap_pulse (wrap_pulse),
        .step_err   (step_err),
        .drop_pulse (drop_pulse),
`ifdef RCS_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (wrap_pulse) wrap_seen++;
            if (step_err)   err_seen++;
            if (drop_pulse) drop_seen++;
            if (out_count == 4'd0) zero_seen++;
        end
    end

    // change cnt_in on a falling edge and hold it for 'hold' cycles
    task automatic step(input logic [3:0] val, input int hold);
        @(negedge clk);
        cnt_in = val;
        repeat (hold) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; out_ready = 1'b0; cnt_in = 4'd5;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
        checks++; if (acc !== 16'd0) begin errors++; $display("FAIL reset_acc got %0d want 0", acc); end
        checks++; if ({acc_sat, wrap_pulse, step_err, drop_pulse} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {acc_sat, wrap_pulse, step_err, drop_pulse}); end
        checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state got %0b want SEED", state_dbg); end
        rst = 1'b0;
    endtask

    task automatic test_seed();
        int n;
        int e0;
        e0 = err_seen;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL seed_timeout no out_valid within %0d cycles", n); end
        checks++; if (n < 5 || n > 6) begin errors++; $display("FAIL seed_latency got %0d cycles want 5..6", n); end
        checks++; if (out_count !== 4'd5) begin errors++; $display("FAIL seed_count got %0d want 5", out_count); end
        checks++; if (acc !== 16'd0) begin errors++; $display("FAIL seed_acc got %0d want 0", acc); end
        checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL seed_state got %0b want TRACK", state_dbg); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL seed_step_err got %0d pulses want 0", err_seen - e0); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seed_consume out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_steps();
        int e0;
        int w0;
        e0 = err_seen; w0 = wrap_seen;
        step(4'd4, 8); step(4'd3, 8); step(4'd2, 8);
        checks++; if (acc !== 16'd3) begin errors++; $display("FAIL steps_acc got %0d want 3", acc); end
        checks++; if (out_count !== 4'd2) begin errors++; $display("FAIL steps_count got %0d want 2", out_count); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL steps_step_err got %0d pulses want 0", err_seen - e0); end
        checks++; if (wrap_seen != w0) begin errors++; $display("FAIL steps_wrap got %0d pulses want 0", wrap_seen - w0); end
    endtask

    task automatic test_wrap();
        int w0;
        int e0;
        step(4'd1, 8); step(4'd0, 8);
        checks++; if (acc !== 16'd5) begin errors++; $display("FAIL wrap_pre_acc got %0d want 5", acc); end
        w0 = wrap_seen; e0 = err_seen;
        step(4'd15, 8);
        checks++; if (wrap_seen - w0 != 1) begin errors++; $display("FAIL wrap_pulse got %0d cycles want 1", wrap_seen - w0); end
        checks++; if (acc !== 16'd6) begin errors++; $display("FAIL wrap_acc got %0d want 6", acc); end
        checks++; if (out_count !== 4'd15) begin errors++; $display("FAIL wrap_count got %0d want 15", out_count); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL wrap_step_err got %0d pulses want 0", err_seen - e0); end
    endtask

    task automatic test_glitch();
        int z0;
        int e0;
        for (int k = 14; k >= 8; k--) step(4'(k), 8);
        checks++; if (acc !== 16'd13) begin errors++; $display("FAIL glitch_pre_acc got %0d want 13", acc); end
        z0 = zero_seen; e0 = err_seen;
        step(4'd0, 1);
        cnt_in = 4'd7;
        repeat (10) @(negedge clk);
        checks++; if (zero_seen != z0) begin errors++; $display("FAIL glitch_zero out_count was 0 for %0d cycles want 0", zero_seen - z0); end
        checks++; if (out_count !== 4'd7) begin errors++; $display("FAIL glitch_count got %0d want 7", out_count); end
        checks++; if (acc !== 16'd14) begin errors++; $display("FAIL glitch_acc got %0d want 14", acc); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL glitch_step_err got %0d pulses want 0", err_seen - e0); end
    endtask

    task automatic test_jump();
        int e0;
        e0 = err_seen;
        step(4'd9, 8);   // 7 -> 9 counting down is 14 steps
        checks++; if (acc !== 16'd28) begin errors++; $display("FAIL jump14_acc got %0d want 28", acc); end
        checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL jump14_step_err got %0d pulses want 1", err_seen - e0); end
        e0 = err_seen;
        step(4'd6, 8);   // 9 -> 6 is 3 steps
        checks++; if (acc !== 16'd31) begin errors++; $display("FAIL jump3_acc got %0d want 31", acc); end
        checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL jump3_step_err got %0d pulses want 1", err_seen - e0); end
`ifdef RCS_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL jump_err_cnt got %0d want 2", err_cnt); end
`endif
    endtask

    task automatic test_drop();
        int d0;
        d0 = drop_seen;
        @(negedge clk);
        out_ready = 1'b0;
        step(4'd5, 8);
        checks++; if (out_valid !== 1'b1 || out_count !== 4'd5) begin errors++; $display("FAIL drop_first got valid=%0b count=%0d want valid=1 count=5", out_valid, out_count); end
        step(4'd4, 8);
        checks++; if (drop_seen - d0 != 1) begin errors++; $display("FAIL drop_pulse got %0d pulses want 1", drop_seen - d0); end
        checks++; if (out_valid !== 1'b1 || out_count !== 4'd4) begin errors++; $display("FAIL drop_second got valid=%0b count=%0d want valid=1 count=4", out_valid, out_count); end
        checks++; if (acc !== 16'd33) begin errors++; $display("FAIL drop_acc got %0d want 33", acc); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_consume out_valid got %0b want 0", out_valid); end
    endtask

    task automatic do_clr(input string tag);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (acc !== 16'd0 || acc_sat !== 1'b0) begin errors++; $display("FAIL %s_acc got acc=%0d sat=%0b want 0/0", tag, acc, acc_sat); end
        checks++; if (state_dbg !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL %s_state got state=%0b valid=%0b want 0/0", tag, state_dbg, out_valid); end
`ifdef RCS_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL %s_err_cnt got %0d want 0", tag, err_cnt); end
`endif
    endtask

    task automatic test_saturate();
        int e0;
        int w0;
        do_clr("clr1");
        e0 = err_seen;
        repeat (8) @(negedge clk);
        checks++; if (state_dbg !== 1'b1 || out_count !== 4'd4 || acc !== 16'd0) begin errors++; $display("FAIL reseed1 got state=%0b count=%0d acc=%0d want 1/4/0", state_dbg, out_count, acc); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL reseed1_step_err got %0d pulses want 0", err_seen - e0); end
        // +1 on a down-counter is a 15-step jump: 4368*15 = 65520, then +14
        v = 4'd4;
        for (int k = 0; k < 4368; k++) begin
            v = v + 4'd1;
            step(v, 6);
        end
        v = v + 4'd2;
        step(v, 6);
        checks++; if (acc !== 16'hFFFE || acc_sat !== 1'b0) begin errors++; $display("FAIL preload got acc=%h sat=%0b want fffe/0", acc, acc_sat); end
        v = v - 4'd1;
        step(v, 6);
        checks++; if (acc !== 16'hFFFF || acc_sat !== 1'b1) begin errors++; $display("FAIL sat_reach got acc=%h sat=%0b want ffff/1", acc, acc_sat); end
        v = v - 4'd1; step(v, 6);
        v = v - 4'd1; step(v, 6);
        checks++; if (acc !== 16'hFFFF || acc_sat !== 1'b1) begin errors++; $display("FAIL sat_hold got acc=%h sat=%0b want ffff/1", acc, acc_sat); end
`ifdef RCS_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat got %0d want 255", err_cnt); end
`endif
        do_clr("clr2");
        e0 = err_seen; w0 = wrap_seen;
        repeat (8) @(negedge clk);
        checks++; if (state_dbg !== 1'b1 || out_count !== v || acc !== 16'd0) begin errors++; $display("FAIL reseed2 got state=%0b count=%0d acc=%0d want 1/%0d/0", state_dbg, out_count, acc, v); end
        checks++; if (err_seen != e0 || wrap_seen != w0) begin errors++; $display("FAIL reseed2_pulses got err=%0d wrap=%0d want 0/0", err_seen - e0, wrap_seen - w0); end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_steps();
        test_wrap();
        test_glitch();
        test_jump();
        test_drop();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
